// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dffnq_pipe.sv
// gf180mcu_fd_sc_mcu9t5v0__dffnq_pipe: negative-edge data pipeline with valid tags, occupancy count and scan chain
module gf180mcu_fd_sc_mcu9t5v0__dffnq_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
`ifdef USE_POWER_PINS
    inout  wire                         VDD,
    inout  wire                         VSS,
`endif
    input  logic                        CLKN,
    input  logic                        RN,
    input  logic [WIDTH-1:0]            D,
    input  logic                        DV,
    input  logic                        EN,
    input  logic                        SE,
    input  logic                        SI,
    output logic [WIDTH-1:0]            Q,
    output logic                        QV,
    output logic                        SO,
    output logic [$clog2(DEPTH+1)-1:0]  CNT
);
    localparam int N  = WIDTH * DEPTH;
    localparam int CW = $clog2(DEPTH + 1);

    // Stage i occupies s[i*WIDTH +: WIDTH], so the scan chain runs from bit 0 up to bit N-1
    logic [N-1:0]     s;
    logic [DEPTH-1:0] v;

    // Reset beats scan beats advance; hold is the implicit else
    always_ff @(negedge CLKN or negedge RN)
        if (!RN) begin
            s   <= {DEPTH{RESET_VAL}};
            v   <= '0;
            CNT <= '0;
        end else if (SE) begin
            s <= N'({s, SI});
        end else if (EN) begin
            s   <= N'({s, D});
            v   <= DEPTH'({v, DV});
            CNT <= CNT + CW'(DV) - CW'(v[DEPTH-1]);
        end

    assign Q  = s[N-1 -: WIDTH];
    assign QV = v[DEPTH-1];
    assign SO = s[N-1];

`ifndef FUNCTIONAL
    specify
        $setuphold(negedge CLKN, D, 0, 0);
        $setuphold(negedge CLKN, DV, 0, 0);
        $setuphold(negedge CLKN, EN, 0, 0);
        $setuphold(negedge CLKN, SE, 0, 0);
        $setuphold(negedge CLKN, SI, 0, 0);
        $width(negedge CLKN, 0);
        $width(posedge CLKN, 0);
        $recrem(posedge RN, negedge CLKN, 0, 0);
    endspecify
`endif
endmodule
